// File: rtl/mc_mem_pkg.sv
// Shared types and constants for the multi-cycle CPU memory port.
package mc_mem_pkg;

  // Port sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUS   = 2'b01,
    FAULT = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Kind of access captured when a request is accepted
  typedef enum logic [1:0] {
    ACC_FETCH = 2'b00,
    ACC_LOAD  = 2'b01,
    ACC_STORE = 2'b10
  } acc_t;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // Classify an access from the controller strobes
  function automatic acc_t acc_decode(input logic iord, input logic memwrite);
    acc_t a;
    if (!iord) begin
      a = ACC_FETCH;
    end else if (memwrite) begin
      a = ACC_STORE;
    end else begin
      a = ACC_LOAD;
    end
    return a;
  endfunction

endpackage

// File: rtl/mc_mem_port_if.sv
// Valid/ready bus between the memory port and the shared memory.
interface mc_mem_port_if;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mc_mem_port.sv
// Unified instruction/data memory access unit for the multi-cycle CPU.
// Owns IR and MDR, sequences one bus access per controller request and
// returns a single-cycle cpu_ready pulse when the access has finished.
module mc_mem_port
  import mc_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [31:0] IR_RST  = INSTR_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        IorD,
  input  logic        MemWrite,
  input  logic [31:0] PC,
  input  logic [31:0] ALUOut,
  input  logic [31:0] B,
  input  logic        err_clr,
  output logic        cpu_ready,
  output logic [31:0] IR,
  output logic [31:0] MDR,
  output logic        mem_err,
  output logic [31:0] err_addr,
  mc_mem_port_if.master mem
);

  // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal
  localparam int unsigned CW = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 32'd0) ? CW'(TIMEOUT - 32'd1) : '0;

  state_t        state_r, state_nx_s;
  acc_t          acc_r, acc_in_s, acc_nx_s;
  logic [CW-1:0] cnt_r;
  logic [31:0]   addr_in_s;
  logic          start_s, cap_s, fault_s, cnt_inc_s;

  assign addr_in_s = IorD ? ALUOut : PC;
  assign acc_in_s  = acc_decode(IorD, MemWrite);
  assign acc_nx_s  = start_s ? acc_in_s : acc_r;

  // Next-state and per-cycle action decode
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    cap_s      = 1'b0;
    fault_s    = 1'b0;
    cnt_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req) begin
          start_s = 1'b1;
          if (addr_in_s[1:0] != 2'b00) begin
            state_nx_s = FAULT;
          end else begin
            state_nx_s = BUS;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUS: begin
        if (mem.mem_ready) begin
          cap_s      = 1'b1;
          state_nx_s = DONE;
        end else if ((TIMEOUT > 32'd0) && (cnt_r == TO_LAST)) begin
          // This wait cycle is the last one allowed: give up on the bus
          fault_s    = 1'b1;
          state_nx_s = DONE;
        end else begin
          cnt_inc_s  = 1'b1;
          state_nx_s = BUS;
        end
      end
      FAULT: begin
        fault_s    = 1'b1;
        state_nx_s = DONE;
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register, bus request outputs and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      acc_r         <= ACC_FETCH;
      cpu_ready     <= 1'b0;
      mem.mem_valid <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'h0000_0000;
      mem.mem_wdata <= 32'h0000_0000;
    end else begin
      state_r       <= state_nx_s;
      cpu_ready     <= (state_nx_s == DONE);
      mem.mem_valid <= (state_nx_s == BUS);
      mem.mem_we    <= (state_nx_s == BUS) && (acc_nx_s == ACC_STORE);
      // Address and data are captured once and held through the handshake
      if (start_s) begin
        acc_r         <= acc_in_s;
        mem.mem_addr  <= addr_in_s;
        mem.mem_wdata <= B;
      end
    end
  end

  // Instruction and memory data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IR  <= IR_RST;
      MDR <= 32'h0000_0000;
    end else begin
      if (acc_r == ACC_FETCH) begin
        if (cap_s) begin
          IR <= mem.mem_rdata;
        end else if (fault_s) begin
          // A failed fetch hands the datapath a harmless instruction
          IR <= IR_RST;
        end
      end
      if (cap_s && (acc_r == ACC_LOAD)) begin
        MDR <= mem.mem_rdata;
      end
    end
  end

  // Sticky error flag; the first faulting address is kept until cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err  <= 1'b0;
      err_addr <= 32'h0000_0000;
    end else if (fault_s) begin
      mem_err <= 1'b1;
      if (!mem_err) begin
        err_addr <= mem.mem_addr;
      end
    end else if (err_clr) begin
      mem_err <= 1'b0;
    end
  end

  // Bus wait counter, restarted after every access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (state_r == DONE) begin
      cnt_r <= '0;
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: tb/tb_mc_mem_port.sv
// Directed self-checking bench for mc_mem_port.
module tb_mc_mem_port;
  import mc_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, IorD, MemWrite, err_clr;
  logic [31:0] PC, ALUOut, B;
  logic        cpu_ready, mem_err;
  logic [31:0] IR, MDR, err_addr;
  int          total;
  int          bad;

  mc_mem_port_if bus ();

  mc_mem_port #(.TIMEOUT(15), .IR_RST(32'h0000_0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .IorD     (IorD),
    .MemWrite (MemWrite),
    .PC       (PC),
    .ALUOut   (ALUOut),
    .B        (B),
    .err_clr  (err_clr),
    .cpu_ready(cpu_ready),
    .IR       (IR),
    .MDR      (MDR),
    .mem_err  (mem_err),
    .err_addr (err_addr),
    .mem      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    cpu_req = 1'b0; IorD = 1'b0; MemWrite = 1'b0; err_clr = 1'b0;
    PC = 32'h0; ALUOut = 32'h0; B = 32'h0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    tick(); tick();
    chk("rst_ir", IR, 32'h0);
    chk("rst_mdr", MDR, 32'h0);
    chk("rst_valid", 32'(bus.mem_valid), 32'h0);
    chk("rst_we", 32'(bus.mem_we), 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_ready", 32'(cpu_ready), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    chk("rst_erraddr", err_addr, 32'h0);
    rst_n = 1'b1;
    tick();

    // Fetch, zero wait
    PC = 32'h0000_0010; IorD = 1'b0; B = 32'hAAAA_0000; cpu_req = 1'b1;
    tick();
    chk("f_valid", 32'(bus.mem_valid), 32'h1);
    chk("f_addr", bus.mem_addr, 32'h10);
    chk("f_we", 32'(bus.mem_we), 32'h0);
    chk("f_rdy_early", 32'(cpu_ready), 32'h0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h2008_0005;
    tick();
    chk("f_rdy", 32'(cpu_ready), 32'h1);
    chk("f_ir", IR, 32'h2008_0005);
    chk("f_valid_off", 32'(bus.mem_valid), 32'h0);
    cpu_req = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'h5555_5555;
    tick();
    chk("f_rdy_pulse", 32'(cpu_ready), 32'h0);
    chk("f_ir_hold", IR, 32'h2008_0005);

    // Load with three wait states; request dropped mid-access
    ALUOut = 32'h0000_0100; IorD = 1'b1; MemWrite = 1'b0; cpu_req = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("l_valid", 32'(bus.mem_valid), 32'h1);
      chk("l_addr", bus.mem_addr, 32'h100);
      chk("l_rdy_early", 32'(cpu_ready), 32'h0);
      cpu_req = 1'b0;
      tick();
    end
    chk("l_valid4", 32'(bus.mem_valid), 32'h1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("l_rdy", 32'(cpu_ready), 32'h1);
    chk("l_mdr", MDR, 32'hDEAD_BEEF);
    chk("l_ir", IR, 32'h2008_0005);
    bus.mem_ready = 1'b0;
    tick();
    chk("l_rdy_pulse", 32'(cpu_ready), 32'h0);

    // Store
    ALUOut = 32'h0000_0200; B = 32'h1234_5678; IorD = 1'b1; MemWrite = 1'b1; cpu_req = 1'b1;
    tick();
    chk("s_valid", 32'(bus.mem_valid), 32'h1);
    chk("s_we", 32'(bus.mem_we), 32'h1);
    chk("s_wdata", bus.mem_wdata, 32'h1234_5678);
    chk("s_addr", bus.mem_addr, 32'h200);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    chk("s_rdy", 32'(cpu_ready), 32'h1);
    chk("s_mdr", MDR, 32'hDEAD_BEEF);
    chk("s_ir", IR, 32'h2008_0005);
    chk("s_we_off", 32'(bus.mem_we), 32'h0);
    cpu_req = 1'b0; bus.mem_ready = 1'b0;
    tick();
    chk("s_rdy_pulse", 32'(cpu_ready), 32'h0);

    // Misaligned load; stray mem_ready must be ignored
    ALUOut = 32'h0000_0102; MemWrite = 1'b0; cpu_req = 1'b1;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_1111;
    tick();
    chk("m_valid", 32'(bus.mem_valid), 32'h0);
    chk("m_rdy_early", 32'(cpu_ready), 32'h0);
    tick();
    chk("m_rdy", 32'(cpu_ready), 32'h1);
    chk("m_err", 32'(mem_err), 32'h1);
    chk("m_erraddr", err_addr, 32'h102);
    chk("m_mdr", MDR, 32'hDEAD_BEEF);
    cpu_req = 1'b0; bus.mem_ready = 1'b0;
    tick();

    // Fetch that times out after 15 bus cycles
    PC = 32'h0000_0040; IorD = 1'b0; cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("t_valid", 32'(bus.mem_valid), 32'h1);
      tick();
    end
    chk("t_valid_off", 32'(bus.mem_valid), 32'h0);
    chk("t_rdy", 32'(cpu_ready), 32'h1);
    chk("t_ir", IR, 32'h0);
    chk("t_erraddr", err_addr, 32'h102);
    chk("t_err", 32'(mem_err), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("c_err", 32'(mem_err), 32'h0);
    chk("c_erraddr", err_addr, 32'h102);

    // Fault while err_clr is held: the set wins and records the new address
    B = 32'h0; PC = 32'h0000_0041; IorD = 1'b0; cpu_req = 1'b1; err_clr = 1'b1;
    tick();
    tick();
    chk("w_err", 32'(mem_err), 32'h1);
    chk("w_erraddr", err_addr, 32'h41);
    chk("w_rdy", 32'(cpu_ready), 32'h1);
    cpu_req = 1'b0;
    tick();
    chk("w_clr", 32'(mem_err), 32'h0);
    err_clr = 1'b0;

    // Back-to-back fetch then load
    PC = 32'h0000_0300; IorD = 1'b0; cpu_req = 1'b1;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h8C08_0004;
    tick();
    chk("b_valid1", 32'(bus.mem_valid), 32'h1);
    chk("b_addr1", bus.mem_addr, 32'h300);
    tick();
    chk("b_rdy1", 32'(cpu_ready), 32'h1);
    chk("b_ir", IR, 32'h8C08_0004);
    IorD = 1'b1; MemWrite = 1'b0; ALUOut = 32'h0000_0304; bus.mem_rdata = 32'h0000_00AB;
    tick();
    chk("b_gap_rdy", 32'(cpu_ready), 32'h0);
    chk("b_gap_valid", 32'(bus.mem_valid), 32'h0);
    tick();
    chk("b_valid2", 32'(bus.mem_valid), 32'h1);
    chk("b_addr2", bus.mem_addr, 32'h304);
    chk("b_rdy_mid", 32'(cpu_ready), 32'h0);
    tick();
    chk("b_rdy2", 32'(cpu_ready), 32'h1);
    chk("b_mdr", MDR, 32'h0000_00AB);
    chk("b_ir_hold", IR, 32'h8C08_0004);
    cpu_req = 1'b0; bus.mem_ready = 1'b0;
    tick();
    chk("b_rdy_pulse", 32'(cpu_ready), 32'h0);

    // Reset in the middle of a bus wait
    PC = 32'h0000_0400; IorD = 1'b0; cpu_req = 1'b1;
    tick();
    chk("r_valid", 32'(bus.mem_valid), 32'h1);
    cpu_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("r_valid_off", 32'(bus.mem_valid), 32'h0);
    chk("r_ir", IR, 32'h0);
    chk("r_addr", bus.mem_addr, 32'h0);
    chk("r_state", 32'(dut.state_r), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    tick();
    PC = 32'h0000_0500; cpu_req = 1'b1;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0123_4567;
    tick();
    chk("r2_addr", bus.mem_addr, 32'h500);
    chk("r2_valid", 32'(bus.mem_valid), 32'h1);
    tick();
    chk("r2_rdy", 32'(cpu_ready), 32'h1);
    chk("r2_ir", IR, 32'h0123_4567);
    cpu_req = 1'b0; bus.mem_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
